// File: rtl/io_access_ctrl.sv
// io_access_ctrl: buffers host commands in a small FIFO and issues them to the
// io_mem_access decoder one beat at a time. Bursts are expanded here. Each read
// waits for returned data or a timeout and produces one response beat.
module io_access_ctrl #(
  parameter int DATA_L      = 32,
  parameter int ADDR_TYPE_L = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int LEN_L       = 8,
  parameter int RD_TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_vld,
  output logic                cmd_rdy,
  input  logic                cmd_wr,
  input  logic [DATA_L-1:0]   cmd_addr,
  input  logic [DATA_L-1:0]   cmd_data,
  input  logic [LEN_L-1:0]    cmd_len,
  output logic [2*DATA_L-1:0] io_in,
  output logic                io_wr_en,
  output logic                io_rd_en,
  input  logic [DATA_L-1:0]   io_out,
  input  logic                io_rd_data_vld,
  output logic                rsp_vld,
  input  logic                rsp_rdy,
  output logic [DATA_L-1:0]   rsp_data,
  output logic                rsp_err,
  output logic                busy
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(RD_TIMEOUT + 1);
  localparam int OFF_L   = DATA_L - ADDR_TYPE_L;
  localparam int ENTRY_W = 1 + 2 * DATA_L + LEN_L;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RSP     = 2'd3
  } state_t;

  // Command FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  // Head-of-FIFO fields
  logic [ENTRY_W-1:0] head;
  logic               head_wr;
  logic [DATA_L-1:0]  head_addr;
  logic [DATA_L-1:0]  head_data;
  logic [LEN_L-1:0]   head_len;

  // Working registers for the command being executed
  state_t             state_q, state_d;
  logic [DATA_L-1:0]  addr_q, addr_d;
  logic [DATA_L-1:0]  data_q, data_d;
  logic               wr_q, wr_d;
  logic [LEN_L-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_L-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;

  // Burst step: only the offset field advances and wraps; the type bits stay put
  function automatic logic [DATA_L-1:0] inc_addr(input logic [DATA_L-1:0] a);
    logic [OFF_L-1:0] off;
    off = a[OFF_L-1:0] + OFF_L'(1);
    return {a[DATA_L-1:OFF_L], off};
  endfunction

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  // Gated with the reset so the host sees "not ready" while the block is held in reset
  assign cmd_rdy    = rst & ~fifo_full;
  assign push       = cmd_vld & cmd_rdy;
  assign pop        = (state_q == IDLE) & ~fifo_empty;

  assign head = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign {head_wr, head_addr, head_data, head_len} = head;

  assign io_in    = {addr_q, data_q};
  assign rsp_vld  = (state_q == RSP);
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;
  assign busy     = (state_q != IDLE) | ~fifo_empty;

  // FIFO next state: write at the tail on push, advance the head on pop
  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop};
    if (push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = {cmd_wr, cmd_addr, cmd_data, cmd_len};
    end
  end

  // FIFO registers; reset discards any buffered commands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Sequencer next state and decoder strobes
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_d       = wr_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    io_wr_en   = 1'b0;
    io_rd_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          addr_d  = head_addr;
          data_d  = head_data;
          wr_d    = head_wr;
          rem_d   = head_len;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        if (wr_q) begin
          io_wr_en = 1'b1;
          if (rem_q == '0) begin
            state_d = IDLE;
          end else begin
            addr_d = inc_addr(addr_q);
            rem_d  = rem_q - LEN_L'(1);
          end
        end else begin
          io_rd_en = 1'b1;
          cnt_d    = '0;
          state_d  = WAIT_RD;
        end
      end

      WAIT_RD: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Data arriving in the last counting cycle takes priority over the timeout
        if (io_rd_data_vld) begin
          rsp_data_d = io_out;
          rsp_err_d  = 1'b0;
          state_d    = RSP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = RSP;
        end
      end

      RSP: begin
        if (rsp_rdy) begin
          if (rem_q == '0) begin
            state_d = IDLE;
          end else begin
            addr_d  = inc_addr(addr_q);
            rem_d   = rem_q - LEN_L'(1);
            state_d = ISSUE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer registers; reset aborts any burst and drops a pending response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      rem_q      <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_q       <= wr_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_io_access_ctrl.sv
// Scoreboard bench for io_access_ctrl: a reference model expands each command
// into expected strobes, decoder replies and responses; a monitor checks them.
module tb_io_access_ctrl;

  localparam int RD_TO = 15;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
    int          cont;
  } strobe_t;

  typedef struct {
    logic [31:0] data;
    bit          err;
    int          lat;
  } rsp_t;

  typedef struct {
    int          k;
    logic [31:0] data;
  } plan_t;

  logic        clk;
  logic        rst;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic        cmd_wr;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic [7:0]  cmd_len;
  logic [63:0] io_in;
  logic        io_wr_en;
  logic        io_rd_en;
  logic [31:0] io_out;
  logic        io_rd_data_vld;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  strobe_t strobe_q[$];
  rsp_t    rsp_q[$];
  plan_t   plan_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rdy_mode = 1;

  io_access_ctrl #(
    .DATA_L(32), .ADDR_TYPE_L(2), .FIFO_DEPTH(4), .LEN_L(8), .RD_TIMEOUT(RD_TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_len(cmd_len),
    .io_in(io_in), .io_wr_en(io_wr_en), .io_rd_en(io_rd_en),
    .io_out(io_out), .io_rd_data_vld(io_rd_data_vld),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Next burst address: low 30 bits advance modulo 2^30, top two type bits kept
  function automatic logic [31:0] nextAddr(input logic [31:0] a);
    logic [31:0] base;
    logic [31:0] off;
    base = a & 32'hC000_0000;
    off  = ((a & 32'h3FFF_FFFF) + 32'd1) % 32'h4000_0000;
    return base | off;
  endfunction

  // Reference model: expand one accepted command into its expected traffic.
  // k = decoder reply delay: 1..RD_TO answered, 0 never, RD_TO+1 too late.
  task automatic modelCommand(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                              input int len, input int kfix, input bit timed, input int push_cyc);
    logic [31:0] a;
    strobe_t     s;
    plan_t       p;
    rsp_t        r;
    int          k;
    a = addr;
    for (int i = 0; i <= len; i++) begin
      s.wr   = wr;
      s.addr = a;
      s.data = data;
      s.due  = (timed && i == 0) ? push_cyc + 2 : -1;
      s.cont = (i == 0) ? 0 : (wr ? 1 : 2);
      strobe_q.push_back(s);
      if (!wr) begin
        k = (kfix >= 0) ? kfix : int'($urandom_range(0, RD_TO + 1));
        p.k    = k;
        p.data = a + 32'd1;
        plan_q.push_back(p);
        if (k >= 1 && k <= RD_TO) begin
          r.data = a + 32'd1;
          r.err  = 1'b0;
          r.lat  = k + 1;
        end else begin
          r.data = 32'd0;
          r.err  = 1'b1;
          r.lat  = RD_TO + 1;
        end
        rsp_q.push_back(r);
      end
      a = nextAddr(a);
    end
  endtask

  // Present one command and hold it until accepted; entered and left at posedge+1
  task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                               input int len, input int kfix, input bit timed);
    bit acc;
    acc      = 1'b0;
    cmd_vld  = 1'b1;
    cmd_wr   = wr;
    cmd_addr = addr;
    cmd_data = data;
    cmd_len  = 8'(len);
    for (int t = 0; t < 2000 && !acc; t++) begin
      @(negedge clk);
      if (cmd_rdy) begin
        acc = 1'b1;
        modelCommand(wr, addr, data, len, kfix, timed, cyc);
      end
      @(posedge clk);
      #1;
    end
    cmd_vld  = 1'b0;
    cmd_addr = $urandom;
    cmd_data = $urandom;
    if (!acc) checkOutput("cmd_accept", 64'(acc), 64'(1));
  endtask

  // Wait for every expected strobe and response to be consumed and the DUT idle
  task automatic drainAll(input string name);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(negedge clk);
      if (strobe_q.size() == 0 && rsp_q.size() == 0 && !busy) done = 1'b1;
    end
    checkOutput(name, 64'(done), 64'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_cmd_rdy"},  64'(cmd_rdy),  64'(0));
    checkOutput({tag, "_io_wr_en"}, 64'(io_wr_en), 64'(0));
    checkOutput({tag, "_io_rd_en"}, 64'(io_rd_en), 64'(0));
    checkOutput({tag, "_io_in"},    io_in,         64'(0));
    checkOutput({tag, "_rsp_vld"},  64'(rsp_vld),  64'(0));
    checkOutput({tag, "_rsp_data"}, 64'(rsp_data), 64'(0));
    checkOutput({tag, "_rsp_err"},  64'(rsp_err),  64'(0));
    checkOutput({tag, "_busy"},     64'(busy),     64'(0));
  endtask

  // Decoder model and host response-ready driver
  initial begin
    bit          pend;
    int          pend_k;
    int          pend_cyc;
    logic [31:0] pend_data;
    plan_t       p;
    pend = 1'b0;
    pend_k = 0;
    pend_cyc = 0;
    pend_data = 32'd0;
    io_rd_data_vld = 1'b0;
    io_out = 32'd0;
    rsp_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (pend && pend_k != 0 && cyc == pend_cyc + pend_k) begin
        io_rd_data_vld = 1'b1;
        io_out = pend_data;
        pend = 1'b0;
      end else begin
        io_rd_data_vld = 1'b0;
        io_out = $urandom;
      end
      case (rdy_mode)
        0:       rsp_rdy = 1'b0;
        1:       rsp_rdy = 1'b1;
        default: rsp_rdy = ($urandom_range(0, 1) == 1);
      endcase
      @(negedge clk);
      if (rst && io_rd_en && plan_q.size() > 0) begin
        p = plan_q.pop_front();
        pend = 1'b1;
        pend_k = p.k;
        pend_cyc = cyc;
        pend_data = p.data;
      end
    end
  end

  // Monitor: compares every strobe and response beat against the scoreboard
  initial begin
    int      last_strobe_cyc;
    int      last_hs_cyc;
    bit      prev_vld;
    strobe_t s;
    rsp_t    r;
    last_strobe_cyc = 0;
    last_hs_cyc = 0;
    prev_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_vld = 1'b0;
      end else begin
        if (io_wr_en && io_rd_en) checkOutput("strobe_exclusive", 64'(1), 64'(0));
        if (io_wr_en || io_rd_en) begin
          if (strobe_q.size() == 0) begin
            checkOutput("strobe_unexpected", 64'(1), 64'(0));
          end else begin
            s = strobe_q.pop_front();
            checkOutput("strobe_kind", 64'({io_wr_en, io_rd_en}), s.wr ? 64'(2) : 64'(1));
            checkOutput("strobe_io_in", io_in, {s.addr, s.data});
            if (s.due >= 0)   checkOutput("strobe_latency", 64'(cyc), 64'(s.due));
            if (s.cont == 1)  checkOutput("write_beat_gap", 64'(cyc - last_strobe_cyc), 64'(1));
            if (s.cont == 2)  checkOutput("read_beat_after_hs", 64'(cyc - last_hs_cyc), 64'(1));
          end
          last_strobe_cyc = cyc;
        end
        if (rsp_vld) begin
          if (rsp_q.size() == 0) begin
            checkOutput("rsp_unexpected", 64'(1), 64'(0));
          end else begin
            if (!prev_vld) checkOutput("rsp_latency", 64'(cyc - last_strobe_cyc), 64'(rsp_q[0].lat));
            checkOutput("rsp_data", 64'(rsp_data), 64'(rsp_q[0].data));
            checkOutput("rsp_err", 64'(rsp_err), 64'(rsp_q[0].err));
            if (rsp_rdy) begin
              r = rsp_q.pop_front();
              last_hs_cyc = cyc;
            end
          end
        end
        prev_vld = rsp_vld && !rsp_rdy;
      end
    end
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    logic [31:0] a;
    rst = 1'b0;
    cmd_vld = 1'b0;
    cmd_wr = 1'b0;
    cmd_addr = 32'd0;
    cmd_data = 32'd0;
    cmd_len = 8'd0;
    #2;
    checkAllZero("in_reset");
    #20;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("cmd_rdy_after_reset", 64'(cmd_rdy), 64'(1));
    @(posedge clk);
    #1;

    $display("[TB] single write");
    rdy_mode = 1;
    applyStimulus(1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 0, 0, 1'b1);
    drainAll("drain_single_write");

    $display("[TB] read burst");
    applyStimulus(1'b0, 32'h8000_0000, 32'h1234_5678, 2, 3, 1'b1);
    drainAll("drain_read_burst");

    $display("[TB] address wrap");
    applyStimulus(1'b1, 32'h3FFF_FFFF, 32'hA5A5_0001, 1, 0, 1'b1);
    drainAll("drain_wrap0");
    applyStimulus(1'b1, 32'h7FFF_FFFF, 32'hA5A5_0002, 1, 0, 1'b1);
    drainAll("drain_wrap1");

    $display("[TB] timeouts");
    applyStimulus(1'b0, 32'h0000_0100, 32'd0, 0, 0, 1'b1);
    drainAll("drain_timeout");
    applyStimulus(1'b0, 32'h0000_0200, 32'd0, 0, RD_TO, 1'b1);
    drainAll("drain_last_cycle_data");
    applyStimulus(1'b0, 32'h0000_0300, 32'd0, 0, RD_TO + 1, 1'b1);
    drainAll("drain_late_data");

    $display("[TB] backpressure");
    rdy_mode = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 32'hC000_0000 + 32'(i * 16), 32'd0, 0, -1, 1'b0);
    end
    @(negedge clk);
    checkOutput("cmd_rdy_full", 64'(cmd_rdy), 64'(0));
    repeat (40) @(posedge clk);
    #1;
    rdy_mode = 1;
    drainAll("drain_backpressure");

    $display("[TB] random traffic");
    rdy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = (a & 32'hC000_0000) | (32'h3FFF_FFFF - $urandom_range(0, 2));
      applyStimulus($urandom_range(0, 1) == 1, a, $urandom, int'($urandom_range(0, 3)), -1, 1'b0);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    drainAll("drain_random");

    $display("[TB] reset during read wait");
    rdy_mode = 1;
    applyStimulus(1'b0, 32'h4000_0040, 32'd0, 0, 8, 1'b1);
    applyStimulus(1'b0, 32'h4000_0080, 32'd0, 1, 3, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkAllZero("async_reset");
    strobe_q.delete();
    rsp_q.delete();
    plan_q.delete();
    @(posedge clk);
    #3;
    rst = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    checkOutput("post_reset_rsp_vld", 64'(rsp_vld), 64'(0));
    checkOutput("post_reset_busy", 64'(busy), 64'(0));
    checkOutput("post_reset_cmd_rdy", 64'(cmd_rdy), 64'(1));
    checkOutput("post_reset_strobe", 64'({io_wr_en, io_rd_en}), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so a stuck DUT cannot hang the run
  initial begin
    #1000000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
